mem_port_arbiter: RTL and testbench

- Shares one single-ported 16-bit memory between the instruction-fetch port and the data-memory port.
- This replaces the separate instruction and data memories with one unified memory behind a handshake.
- The data port has priority, with a starvation guard for fetch.
- Sequences one access at a time: grant, issue, wait for completion, respond.
- Flags misaligned addresses and memory timeouts.

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/mem_arb_pick.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared encodings for the unified memory port arbiter: FSM state codes and
//   the owner code of the access currently in flight.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
//   Owner selection between fetch and data requesters. Data wins unless fetch
//   has already been passed over STARVE_MAX times in a row.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   if_req        fetch request
//   dm_req        data request
//   grant         an access is being granted this cycle (owner is latched)
//   owner         combinational winner for the current requests
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   if_req,
  input  logic   dm_req,
  input  logic   grant,
  output owner_t owner
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt;

  always_comb begin
    owner = OWN_IF;
    if (dm_req && (!if_req || (starve_cnt < SW'(STARVE_MAX))))
      owner = OWN_DM;
  end

  // Counts data grants that happened while fetch was waiting; any grant that
  // did not pass fetch over resets the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (grant) begin
      if ((owner == OWN_DM) && if_req) begin
        if (starve_cnt < SW'(STARVE_MAX))
          starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported 16-bit memory between the instruction-fetch port
//   and the data port. One access at a time: grant, issue, wait, respond.
//   Misaligned addresses and memory timeouts complete with acc_err.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   if_req, if_addr             fetch request (read only)
//   dm_req, dm_wr, dm_addr,
//   dm_wdata                    data request (load or store)
//   if_ack, dm_ack              one-cycle completion pulses
//   rdata, acc_err              response data / error, valid with an ack
//   busy                        access in progress
//   mem_en, mem_wr, mem_addr,
//   mem_wdata                   memory request (mem_en is a one-cycle strobe)
//   mem_rdata, mem_done         memory response
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for a request; owner picked and request latched
// S_ISSUE | mem_en strobe cycle; zero-latency completion accepted
// S_WAIT  | waiting for mem_done, bounded by TIMEOUT cycles
// S_RESP  | ack pulse to owner with rdata/acc_err
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic        if_ack,
  output logic        dm_ack,
  output logic [15:0] rdata,
  output logic        acc_err,
  output logic        busy,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  arb_state_t  state;
  owner_t      owner;
  owner_t      pick_owner;
  logic        grant;
  logic [15:0] sel_addr;
  logic [TW-1:0] tcnt;

  assign grant    = (state == S_IDLE) && (if_req || dm_req);
  assign sel_addr = (pick_owner == OWN_DM) ? dm_addr : if_addr;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk    (clk),
    .rst    (rst),
    .if_req (if_req),
    .dm_req (dm_req),
    .grant  (grant),
    .owner  (pick_owner)
  );

  // The latched request lives directly in the mem_* output registers, so the
  // memory sees stable address/data for the whole access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      owner     <= OWN_IF;
      tcnt      <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      rdata     <= '0;
      acc_err   <= 1'b0;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= 1'b0;
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant) begin
            owner     <= pick_owner;
            busy      <= 1'b1;
            mem_addr  <= sel_addr;
            mem_wr    <= (pick_owner == OWN_DM) && dm_wr;
            mem_wdata <= (pick_owner == OWN_DM) ? dm_wdata : 16'h0000;
            if (sel_addr[0]) begin
              acc_err <= 1'b1;
              rdata   <= '0;
              if_ack  <= (pick_owner == OWN_IF);
              dm_ack  <= (pick_owner == OWN_DM);
              state   <= S_RESP;
            end else begin
              acc_err <= 1'b0;
              mem_en  <= 1'b1;
              state   <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          tcnt <= '0;
          if (mem_done) begin
            rdata  <= mem_wr ? 16'h0000 : mem_rdata;
            if_ack <= (owner == OWN_IF);
            dm_ack <= (owner == OWN_DM);
            state  <= S_RESP;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_done) begin
            rdata  <= mem_wr ? 16'h0000 : mem_rdata;
            if_ack <= (owner == OWN_IF);
            dm_ack <= (owner == OWN_DM);
            state  <= S_RESP;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            acc_err <= 1'b1;
            rdata   <= '0;
            if_ack  <= (owner == OWN_IF);
            dm_ack  <= (owner == OWN_DM);
            state   <= S_RESP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_RESP: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 3;
  localparam int TIMEOUT    = 15;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        dm_req;
  logic        dm_wr;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic        if_ack;
  logic        dm_ack;
  logic [15:0] rdata;
  logic        acc_err;
  logic        busy;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_done;

  logic        zero_lat;
  logic        done_drv;
  logic [15:0] mem_arr [512];

  int n_checks = 0;
  int n_errors = 0;
  int starve_m = 0;
  bit last_dm  = 1'b0;

  mem_port_arbiter #(
    .STARVE_MAX (STARVE_MAX),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .dm_req    (dm_req),
    .dm_wr     (dm_wr),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .if_ack    (if_ack),
    .dm_ack    (dm_ack),
    .rdata     (rdata),
    .acc_err   (acc_err),
    .busy      (busy),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_done  (mem_done)
  );

  // Memory model: word-addressed array, done either tied to mem_en or pulsed.
  assign mem_done  = zero_lat ? mem_en : done_drv;
  assign mem_rdata = mem_arr[mem_addr[9:1]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One access from the current requests (DUT idle, called on a negedge).
  // lat: cycles from mem_en to mem_done (0 = tied, >TIMEOUT = never answers).
  task automatic run_access(input int lat, input bit keep);
    bit          own_dm;
    bit          w;
    bit          mis;
    bit          tmo;
    logic [15:0] a;
    logic [15:0] wd;
    logic [15:0] exp_rd;
    int          exp_k;
    int          en_k;
    int          en_n;
    int          ack_k;
    own_dm = dm_req && (!if_req || (starve_m < STARVE_MAX));
    if (own_dm && if_req) starve_m = (starve_m < STARVE_MAX) ? starve_m + 1 : starve_m;
    else starve_m = 0;
    a   = own_dm ? dm_addr : if_addr;
    w   = own_dm && dm_wr;
    wd  = dm_wdata;
    mis = a[0];
    tmo = !mis && (lat > TIMEOUT);
    exp_k  = mis ? 1 : (tmo ? TIMEOUT + 2 : lat + 2);
    exp_rd = (mis || tmo || w) ? 16'h0000 : mem_arr[a[9:1]];
    zero_lat = (lat == 0);
    done_drv = 1'b0;
    en_k = 0;
    en_n = 0;
    ack_k = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (mem_en) begin
        en_n++;
        en_k = k;
        chk("mem_addr", mem_addr, a);
        chk("mem_wr", mem_wr, w);
        if (w) chk("mem_wdata", mem_wdata, wd);
        if (lat == 0 && w) mem_arr[a[9:1]] = wd;
      end
      if (!tmo && lat > 0 && en_k != 0 && k == en_k + lat) begin
        done_drv = 1'b1;
        if (w) mem_arr[a[9:1]] = wd;
      end else begin
        done_drv = 1'b0;
      end
      if (if_ack || dm_ack) begin
        ack_k = k;
        break;
      end
    end
    done_drv = 1'b0;
    last_dm  = dm_ack;
    chk("ack_cycle", ack_k, exp_k);
    chk("if_ack", if_ack, !own_dm);
    chk("dm_ack", dm_ack, own_dm);
    chk("rdata", rdata, exp_rd);
    chk("acc_err", acc_err, mis || tmo);
    chk("mem_en_count", en_n, mis ? 0 : 1);
    if (!mis) chk("mem_en_cycle", en_k, 1);
    if (!keep) begin
      if (own_dm) dm_req = 1'b0;
      else if_req = 1'b0;
    end
    zero_lat = 1'b0;
    @(negedge clk);
    chk("busy_after_resp", busy, 1'b0);
  endtask

  function automatic logic [15:0] rnd_addr();
    logic [15:0] a;
    a = 16'($urandom);
    a[0] = ($urandom_range(0, 7) == 0);
    return a;
  endfunction

  initial begin
    int extra;
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_wr = 1'b0; dm_addr = '0; dm_wdata = '0;
    zero_lat = 1'b0; done_drv = 1'b0;
    for (int i = 0; i < 512; i++) mem_arr[i] = 16'($urandom);

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_acks", {if_ack, dm_ack}, 2'b00);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_acc_err", acc_err, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    // Single fetch, zero-latency memory.
    mem_arr[16'h0010 >> 1] = 16'hABCD;
    if_req = 1'b1; if_addr = 16'h0010;
    run_access(0, 1'b0);
    chk("fetch_rdata_const", rdata, 16'hABCD);

    // Store.
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0200; dm_wdata = 16'h1234;
    run_access(1, 1'b0);

    // Misaligned data access.
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0003;
    run_access(2, 1'b0);

    // Fetch timeout, then a late mem_done pulse must not produce an ack.
    if_req = 1'b1; if_addr = 16'h0040;
    run_access(99, 1'b0);
    done_drv = 1'b1;
    @(negedge clk);
    done_drv = 1'b0;
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (if_ack || dm_ack || busy) extra++;
    end
    chk("late_done_ignored", extra, 0);

    // Contention: both requests held, grant order DM,DM,DM,IF repeating.
    if_req = 1'b1; if_addr = 16'h0100;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0102;
    for (int i = 0; i < 8; i++) begin
      run_access(2, 1'b1);
      chk("contention_order", last_dm, (i % 4) != 3);
    end
    if_req = 1'b0; dm_req = 1'b0;
    @(negedge clk);

    // Randomized traffic against the reference model.
    for (int it = 0; it < 60; it++) begin
      int r;
      int lat;
      if (!if_req && $urandom_range(0, 2) != 0) begin
        if_req = 1'b1; if_addr = rnd_addr();
      end
      if (!dm_req && ($urandom_range(0, 2) != 0 || !if_req)) begin
        dm_req = 1'b1; dm_wr = 1'($urandom_range(0, 1));
        dm_addr = rnd_addr(); dm_wdata = 16'($urandom);
      end
      r = $urandom_range(0, 9);
      lat = (r < 6) ? (r % 5) : ((r == 6) ? 15 : ((r == 7) ? 16 : ((r == 8) ? 3 : 99)));
      run_access(lat, 1'b0);
    end
    if_req = 1'b0; dm_req = 1'b0;
    @(negedge clk);

    // Reset mid-access with starvation count built up.
    if_req = 1'b1; if_addr = 16'h0010;
    run_access(0, 1'b0);
    if_req = 1'b1; if_addr = 16'h0020;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0030;
    run_access(2, 1'b1);
    run_access(2, 1'b1);
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_mem_en", mem_en, 1'b0);
    chk("midrst_acks", {if_ack, dm_ack}, 2'b00);
    if_req = 1'b0; dm_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy || mem_en || if_ack || dm_ack) extra++;
    end
    chk("post_rst_idle", extra, 0);
    starve_m = 0;
    if_req = 1'b1; dm_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_access(2, 1'b1);
      chk("post_rst_order", last_dm, i != 3);
    end
    if_req = 1'b0; dm_req = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
